// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: LOOK-scheduled single-car elevator controller.
// Optional travel watchdog enabled by defining ELEVATOR_TRAVEL_WATCHDOG_EN.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS       = 5,
    parameter int FLOOR_W          = 3,
    parameter int DOOR_OPEN_CYCLES = 8,
    parameter int TRAVEL_TIMEOUT   = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_sensors,
    input  logic [NUM_FLOORS-1:0] request_buttons,
    input  logic [NUM_FLOORS-1:0] elevator_buttons,
    output logic                  dir,
    output logic                  move,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  floor_valid,
    output logic                  fault
);
    localparam int TW = $clog2(DOOR_OPEN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR, FAULT} state_t;

    state_t                state_q, state_d;
    logic                  dir_q, dir_d, move_q, move_d, door_q, door_d;
    logic                  valid_q, valid_d, fault_q, fault_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, calls, fbit_q, fbit_s;
    logic [FLOOR_W-1:0]    floor_q, floor_d, idx;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  onehot, multi, arrive, terminal, wd_trip;

    function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] p, input int f, input logic up);
        calls_ahead = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (p[i] && (up ? (i > f) : (i < f))) calls_ahead = 1'b1;
    endfunction

    assign calls    = request_buttons | elevator_buttons;
    assign onehot   = $onehot(floor_sensors);
    assign multi    = !$onehot0(floor_sensors);
    assign fbit_q   = NUM_FLOORS'(1) << floor_q;
    assign fbit_s   = NUM_FLOORS'(1) << idx;
    assign arrive   = onehot && (idx != floor_q || !valid_q);
    assign terminal = (idx == '0 && !dir_q) || (idx == FLOOR_W'(NUM_FLOORS - 1) && dir_q);

    // Index of the (highest) asserted floor sensor
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (floor_sensors[i]) idx = FLOOR_W'(i);
    end

`ifdef ELEVATOR_TRAVEL_WATCHDOG_EN
    localparam int WW = $clog2(TRAVEL_TIMEOUT + 1);
    logic [WW-1:0]         wd_q;
    logic [NUM_FLOORS-1:0] sens_q;
    logic                  wd_run;
    assign wd_run  = state_q == MOVE && floor_sensors == sens_q;
    assign wd_trip = wd_run && wd_q == WW'(TRAVEL_TIMEOUT - 1);
    // Travel watchdog: counts MOVE cycles without a sensor change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q   <= '0;
            sens_q <= '0;
        end else begin
            sens_q <= floor_sensors;
            wd_q   <= wd_run ? wd_q + WW'(1) : '0;
        end
    end
`else
    assign wd_trip = 1'b0;
`endif

    // Next-state, call latching and LOOK direction decisions
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        move_d    = move_q;
        door_d    = door_q;
        fault_d   = fault_q;
        timer_d   = timer_q;
        pending_d = pending_q | calls;
        floor_d   = onehot ? idx : floor_q;
        valid_d   = valid_q | onehot;
        case (state_q)
            IDLE: begin
                if (!valid_q) begin
                    if (|pending_q) begin
                        dir_d   = 1'b0;
                        move_d  = 1'b1;
                        state_d = MOVE;
                    end
                end else if (pending_q[floor_q]) begin
                    pending_d = pending_d & ~fbit_q;
                    timer_d   = TW'(DOOR_OPEN_CYCLES);
                    door_d    = 1'b1;
                    state_d   = DOOR;
                end else if (calls_ahead(pending_q, int'(floor_q), dir_q)) begin
                    move_d  = 1'b1;
                    state_d = MOVE;
                end else if (calls_ahead(pending_q, int'(floor_q), !dir_q)) begin
                    dir_d   = !dir_q;
                    move_d  = 1'b1;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (arrive) begin
                    if (pending_d[idx]) begin
                        pending_d = pending_d & ~fbit_s;
                        move_d    = 1'b0;
                        door_d    = 1'b1;
                        timer_d   = TW'(DOOR_OPEN_CYCLES);
                        state_d   = DOOR;
                    end else if (!calls_ahead(pending_d, int'(idx), dir_q) || terminal) begin
                        move_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DOOR: begin
                if (|(calls & fbit_q)) begin
                    pending_d = pending_d & ~fbit_q;
                    timer_d   = TW'(DOOR_OPEN_CYCLES);
                end else if (timer_q == TW'(1)) begin
                    door_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                move_d  = 1'b0;
                door_d  = 1'b0;
                fault_d = 1'b1;
            end
        endcase
        if (multi || wd_trip) begin
            state_d = FAULT;
            move_d  = 1'b0;
            door_d  = 1'b0;
            fault_d = 1'b1;
        end
    end

    // State and registered command outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dir_q     <= 1'b1;
            move_q    <= 1'b0;
            door_q    <= 1'b0;
            fault_q   <= 1'b0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            floor_q   <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            move_q    <= move_d;
            door_q    <= door_d;
            fault_q   <= fault_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            floor_q   <= floor_d;
            timer_q   <= timer_d;
        end
    end

    assign dir           = dir_q;
    assign move          = move_q;
    assign door_open     = door_q;
    assign pending       = pending_q;
    assign current_floor = floor_q;
    assign floor_valid   = valid_q;
    assign fault         = fault_q;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb_elevator_request_scheduler: directed scenarios plus model-checked random traffic.
module tb_elevator_request_scheduler;
    localparam int N  = 5;
    localparam int FW = 3;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  sens = '0, rb = '0, eb = '0;
    logic          dir, move, door_open, floor_valid, fault;
    logic [N-1:0]  pending;
    logic [FW-1:0] current_floor;
    int            tests = 0, fails = 0;

    elevator_request_scheduler #(.NUM_FLOORS(N), .FLOOR_W(FW), .DOOR_OPEN_CYCLES(D), .TRAVEL_TIMEOUT(200)) dut (
        .clk(clk), .reset(reset), .floor_sensors(sens), .request_buttons(rb), .elevator_buttons(eb),
        .dir(dir), .move(move), .door_open(door_open), .pending(pending),
        .current_floor(current_floor), .floor_valid(floor_valid), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        sens = '0;
        rb = '0;
        eb = '0;
        tick;
        reset = 1'b1;
    endtask

    task automatic press(input logic [N-1:0] v);
        if ($urandom_range(0, 1) == 1) rb = v; else eb = v;
        tick;
        rb = '0;
        eb = '0;
    endtask

    // Behavioural reference: states 0 idle, 1 moving, 2 door, 3 fault
    int           m_state, m_floor, m_timer;
    bit           m_dir, m_move, m_door, m_valid, m_fault;
    logic [N-1:0] m_pend;

    task automatic model_reset;
        m_state = 0; m_floor = 0; m_timer = 0;
        m_dir = 1; m_move = 0; m_door = 0; m_valid = 0; m_fault = 0;
        m_pend = '0;
    endtask

    function automatic bit beyond(input logic [N-1:0] p, input int f, input bit up);
        for (int i = 0; i < N; i++)
            if (p[i] && (up ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic [N-1:0] s, input logic [N-1:0] c);
        int hot = 0, f = 0, st = m_state, fl = m_floor;
        bit v = m_valid;
        logic [N-1:0] p = m_pend, all;
        all = p | c;
        for (int i = 0; i < N; i++)
            if (s[i]) begin hot++; f = i; end
        m_pend = all;
        if (hot == 1) begin m_floor = f; m_valid = 1; end
        if (hot > 1 || st == 3) begin
            m_state = 3; m_move = 0; m_door = 0; m_fault = 1;
        end else if (st == 0) begin
            if (!v) begin
                if (p != 0) begin m_dir = 0; m_move = 1; m_state = 1; end
            end else if (p[fl]) begin
                m_pend[fl] = 1'b0; m_timer = D; m_door = 1; m_state = 2;
            end else if (beyond(p, fl, m_dir)) begin
                m_move = 1; m_state = 1;
            end else if (beyond(p, fl, !m_dir)) begin
                m_dir = !m_dir; m_move = 1; m_state = 1;
            end
        end else if (st == 1) begin
            if (hot == 1 && (f != fl || !v)) begin
                if (all[f]) begin
                    m_pend[f] = 1'b0; m_move = 0; m_door = 1; m_timer = D; m_state = 2;
                end else if (!beyond(all, f, m_dir) || (f == 0 && !m_dir) || (f == N - 1 && m_dir)) begin
                    m_move = 0; m_state = 0;
                end
            end
        end else begin
            if (c[fl]) begin m_pend[fl] = 1'b0; m_timer = D; end
            else if (m_timer == 1) begin m_door = 0; m_state = 0; end
            else m_timer--;
        end
    endtask

    task automatic test_reset;
        logic [12:0] exp = {1'b1, 1'b0, 1'b0, 5'b0, 3'b0, 1'b0, 1'b0};
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({dir, move, door_open, pending, current_floor, floor_valid, fault} !== exp) begin
            fails++;
            $display("FAIL reset_async: got %b expected %b", {dir, move, door_open, pending, current_floor, floor_valid, fault}, exp);
        end
        rb = 5'b11111;
        tick;
        rb = '0;
        tests++;
        if ({dir, move, door_open, pending, current_floor, floor_valid, fault} !== exp) begin
            fails++;
            $display("FAIL reset_held: got %b expected %b", {dir, move, door_open, pending, current_floor, floor_valid, fault}, exp);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_trip;
        int cnt = 1;
        do_reset;
        sens = 5'b00001;
        press(5'b00010);
        tests++;
        if (pending !== 5'b00010 || move !== 1'b0) begin
            fails++;
            $display("FAIL basic_latch: pending %b move %b expected 00010 0", pending, move);
        end
        tick;
        tests++;
        if (dir !== 1'b1 || move !== 1'b1) begin
            fails++;
            $display("FAIL basic_depart: dir %b move %b expected 1 1", dir, move);
        end
        sens = '0;
        tick;
        tick;
        sens = 5'b00010;
        tick;
        tests++;
        if ({move, door_open, pending, current_floor} !== {1'b0, 1'b1, 5'b0, 3'd1}) begin
            fails++;
            $display("FAIL basic_stop: move %b door %b pending %b floor %0d expected 0 1 00000 1", move, door_open, pending, current_floor);
        end
        for (int k = 0; k < 20; k++) begin
            tick;
            if (!door_open) break;
            cnt++;
        end
        tests++;
        if (cnt != D || move !== 1'b0) begin
            fails++;
            $display("FAIL basic_door_len: %0d cycles move %b expected %0d cycles move 0", cnt, move, D);
        end
    endtask

    task automatic test_look_reversal;
        do_reset;
        sens = 5'b00100;
        tick;
        press(5'b10001);
        tick;
        tests++;
        if (move !== 1'b1 || dir !== 1'b1) begin
            fails++;
            $display("FAIL look_start: move %b dir %b expected 1 1", move, dir);
        end
        sens = '0; tick;
        sens = 5'b01000; tick;
        tests++;
        if ({move, dir, current_floor} !== {1'b1, 1'b1, 3'd3}) begin
            fails++;
            $display("FAIL look_pass3: move %b dir %b floor %0d expected 1 1 3", move, dir, current_floor);
        end
        sens = '0; tick;
        sens = 5'b10000; tick;
        tests++;
        if ({door_open, move, dir, pending, current_floor} !== {1'b1, 1'b0, 1'b1, 5'b00001, 3'd4}) begin
            fails++;
            $display("FAIL look_serve4: door %b move %b dir %b pending %b floor %0d expected 1 0 1 00001 4", door_open, move, dir, pending, current_floor);
        end
        for (int k = 0; k < 30; k++) begin
            tick;
            if (move) break;
        end
        tests++;
        if (move !== 1'b1 || dir !== 1'b0) begin
            fails++;
            $display("FAIL look_reverse: move %b dir %b expected 1 0", move, dir);
        end
        for (int f = 3; f >= 0; f--) begin
            sens = '0; tick;
            sens = N'(1) << f; tick;
            if (f > 0) begin
                tests++;
                if (move !== 1'b1 || dir !== 1'b0) begin
                    fails++;
                    $display("FAIL look_down_f%0d: move %b dir %b expected 1 0", f, move, dir);
                end
            end
        end
        tests++;
        if ({door_open, move, pending, current_floor} !== {1'b1, 1'b0, 5'b0, 3'd0}) begin
            fails++;
            $display("FAIL look_serve0: door %b move %b pending %b floor %0d expected 1 0 00000 0", door_open, move, pending, current_floor);
        end
    endtask

    task automatic test_door_reload;
        int cnt = 1;
        do_reset;
        sens = 5'b00100;
        tick;
        press(5'b00100);
        tick;
        tests++;
        if (door_open !== 1'b1 || pending !== 5'b0) begin
            fails++;
            $display("FAIL reload_open: door %b pending %b expected 1 00000", door_open, pending);
        end
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) eb = 5'b00100;
            tick;
            eb = '0;
            if (!door_open) break;
            cnt++;
        end
        tests++;
        if (cnt != 13 || pending !== 5'b0) begin
            fails++;
            $display("FAIL reload_len: %0d cycles pending %b expected 13 cycles 00000", cnt, pending);
        end
    endtask

    task automatic test_homing;
        do_reset;
        press(5'b10000);
        tick;
        tests++;
        if ({dir, move, floor_valid} !== 3'b010) begin
            fails++;
            $display("FAIL home_start: dir %b move %b valid %b expected 0 1 0", dir, move, floor_valid);
        end
        repeat (250) tick;
`ifdef ELEVATOR_TRAVEL_WATCHDOG_EN
        tests++;
        if (fault !== 1'b1 || move !== 1'b0) begin
            fails++;
            $display("FAIL home_watchdog: fault %b move %b expected 1 0", fault, move);
        end
`else
        tests++;
        if ({fault, move, dir} !== 3'b010) begin
            fails++;
            $display("FAIL home_no_watchdog: fault %b move %b dir %b expected 0 1 0", fault, move, dir);
        end
        sens = 5'b00100;
        tick;
        tests++;
        if ({move, floor_valid, current_floor} !== {1'b0, 1'b1, 3'd2}) begin
            fails++;
            $display("FAIL home_found: move %b valid %b floor %0d expected 0 1 2", move, floor_valid, current_floor);
        end
        tick;
        tests++;
        if (move !== 1'b1 || dir !== 1'b1) begin
            fails++;
            $display("FAIL home_turn_up: move %b dir %b expected 1 1", move, dir);
        end
        sens = '0; tick;
        sens = 5'b01000; tick;
        sens = '0; tick;
        sens = 5'b10000; tick;
        tests++;
        if ({door_open, move, pending, current_floor} !== {1'b1, 1'b0, 5'b0, 3'd4}) begin
            fails++;
            $display("FAIL home_arrive4: door %b move %b pending %b floor %0d expected 1 0 00000 4", door_open, move, pending, current_floor);
        end
`endif
    endtask

    task automatic test_fault;
        do_reset;
        sens = 5'b00001;
        press(5'b00100);
        tick;
        sens = '0; tick;
        sens = 5'b00110; tick;
        tests++;
        if ({fault, move, door_open} !== 3'b100) begin
            fails++;
            $display("FAIL fault_set: fault %b move %b door %b expected 1 0 0", fault, move, door_open);
        end
        sens = '0;
        press(5'b01000);
        repeat (5) tick;
        tests++;
        if ({fault, move, pending} !== {1'b1, 1'b0, 5'b01100}) begin
            fails++;
            $display("FAIL fault_hold: fault %b move %b pending %b expected 1 0 01100", fault, move, pending);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (fault !== 1'b0 || pending !== 5'b0) begin
            fails++;
            $display("FAIL fault_clear: fault %b pending %b expected 0 00000", fault, pending);
        end
        reset = 1'b1;
    endtask

    task automatic test_async_reset;
        do_reset;
        sens = 5'b00001;
        press(5'b10000);
        tick;
        sens = '0;
        #3 reset = 1'b0;
        #1;
        tests++;
        if (move !== 1'b0 || floor_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_move_drop: move %b valid %b expected 0 0", move, floor_valid);
        end
        reset = 1'b1;
        tick;
        press(5'b00010);
        tick;
        tests++;
        if (move !== 1'b1 || dir !== 1'b0) begin
            fails++;
            $display("FAIL async_rehome: move %b dir %b expected 1 0", move, dir);
        end
    endtask

    task automatic test_random_traffic;
        int pos2;
        logic [12:0] got, exp;
        do_reset;
        model_reset;
        pos2 = $urandom_range(0, 2 * N - 2);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sens = (pos2 % 2 == 0) ? N'(1) << (pos2 / 2) : '0;
            rb = ($urandom_range(0, 5) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
            eb = ($urandom_range(0, 7) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
            tick;
            model_step(sens, rb | eb);
            got = {dir, move, door_open, pending, current_floor, floor_valid, fault};
            exp = {m_dir, m_move, m_door, m_pend, FW'(m_floor), m_valid, m_fault};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL random cycle %0d: got %b expected %b", cyc, got, exp);
            end
            if (m_move && $urandom_range(0, 1) == 1) pos2 += m_dir ? 1 : -1;
            if (pos2 < 0) pos2 = 0;
            if (pos2 > 2 * N - 2) pos2 = 2 * N - 2;
        end
        rb = '0;
        eb = '0;
    endtask

    initial begin
        test_reset;
        test_basic_trip;
        test_look_reversal;
        test_door_reload;
        test_homing;
        test_fault;
        test_async_reset;
        test_random_traffic;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Single-car elevator scheduler for a NUM_FLOORS-stop shaft.
- Latches hall calls (request_buttons) and cab calls (elevator_buttons) into a pending register.
- Tracks car position from one-hot floor_sensors and issues registered dir/move/door_open commands using LOOK scheduling: keep travelling while calls remain ahead, reverse only when none do.
- Sits between the button/sensor inputs and the hoist motor/door drivers; replaces ad-hoc direction logic.

Parameters:
- NUM_FLOORS, 5: number of floors; sets width of all floor vectors.
- FLOOR_W, 3: width of current_floor; must satisfy 2^FLOOR_W >= NUM_FLOORS.
- DOOR_OPEN_CYCLES, 8: clock cycles door_open stays high per stop (>=2).
- TRAVEL_TIMEOUT, 200: cycles allowed between floor-sensor events while moving (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- floor_sensors  input  NUM_FLOORS  one-hot car-at-floor; all-zero = between floors.
- request_buttons  input  NUM_FLOORS  hall-call pulses, bit i = floor i.
- elevator_buttons  input  NUM_FLOORS  cab-call pulses, bit i = floor i.
- dir  output  1  1 = up, 0 = down.
- move  output  1  motor run command.
- door_open  output  1  door open command.
- pending  output  NUM_FLOORS  latched calls, drives button lamps.
- current_floor  output  FLOOR_W  last floor sensed.
- floor_valid  output  1  current_floor has been established since reset.
- fault  output  1  sticky fault indicator.

Behaviour:
- Reset (reset low, async): state=IDLE, dir=1, move=0, door_open=0, pending=0, current_floor=0, floor_valid=0, fault=0, door timer=0. All outputs are registered.
- Call latching: pending <= pending | request_buttons | elevator_buttons every cycle. A press at edge n appears on pending at n+1.
- Exception to latching: presses for current_floor while in DOOR are not latched; they reload the door timer.
- Sensor decode, one-hot: current_floor <= index, floor_valid <= 1.
- Sensor decode, zero: hold current_floor.
- Sensor decode, more than one bit set: go to FAULT.
- States: IDLE, MOVE, DOOR, FAULT.
- IDLE, floor_valid=0 and pending!=0: dir<=0, move<=1, go to MOVE (home downward until the first sensor).
- IDLE, floor_valid=1, evaluated in priority order:
  - pending[current_floor] set: clear the bit, load timer=DOOR_OPEN_CYCLES, door_open<=1, go to DOOR.
  - else any call ahead in the current dir: keep dir, move<=1, go to MOVE.
  - else any call in the opposite direction: flip dir, move<=1, go to MOVE.
  - else stay in IDLE.
- MOVE, new one-hot sensor at floor f (f differs from current_floor, or floor_valid was 0): update current_floor.
  - pending[f] set: move<=0, clear pending[f], door_open<=1, load timer, go to DOOR in the same cycle. Stop latency = 1 cycle after the sensor is sampled.
  - else no call ahead in dir, or f is a terminal floor (0 going down, NUM_FLOORS-1 going up): move<=0, go to IDLE.
- DOOR: timer decrements each cycle. Reaching 1 gives door_open<=0 and a return to IDLE. move stays 0 throughout.
- Simultaneous events: a call for a floor the car is departing from in the same cycle is kept pending and served later. A sensor edge and a call for that same floor in the same cycle stops the car.
- FAULT: move=0, door_open=0, fault=1. Held until reset. pending still latches.
- Reset mid-move: move drops asynchronously, floor_valid=0, and the car re-homes on the next call.

Optional Feature:
- Macro: ELEVATOR_TRAVEL_WATCHDOG_EN.
- Defined: a counter clears on every sensor change and on entry to MOVE, and counts while in MOVE. Reaching TRAVEL_TIMEOUT forces FAULT (move=0, fault=1).
- Undefined: no counter, and fault is set only by a multi-hot sensor. TRAVEL_TIMEOUT is unused.

Test Plan:
- Reset, then floor_sensors=00001 with request_buttons=00010 pulsed:
  - pending=00010, dir=1, move=1 within 2 cycles.
  - After sensors=00010: move=0 next cycle, door_open high 8 cycles, pending=00000.
- Car at floor 2 moving up with pending=10001: passes floors 3 and 4 before reversing. dir flips to 0 only after floor 4 is served, then floor 0 is served.
- In DOOR at floor 2, elevator_buttons=00100 pulsed on cycle 5: timer reloads, door_open total = 13 cycles, pending bit 2 stays 0.
- Unknown floor after reset, elevator_buttons=10000: dir=0 and move=1 until the first sensor, then up to floor 4.
- floor_sensors=00110 while moving: fault=1, move=0 next cycle, held until reset is pulled low.
- With ELEVATOR_TRAVEL_WATCHDOG_EN and TRAVEL_TIMEOUT=200, sensors held 00000 in MOVE: fault rises on cycle 200. Without the macro, move stays 1.
